// File: rtl/rv_decode_pkg.sv
// Shared constants for the RV32I ALU-subset decode/issue front end:
// ALU control codes, opcode/funct fields and the issue FSM encoding.
package rv_decode_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } issue_state_t;

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational decode of one RV32I word into register names, ALU control and
// immediate. Fields are raw for unsupported words; legal says whether to use them.
module rv_alu_decode
    import rv_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NAME_BITS  = 5,
    parameter int CTRL_BITS  = 4
) (
    input  logic [31:0]           instr,
    output logic [NAME_BITS-1:0]  rs1,
    output logic [NAME_BITS-1:0]  rs2,
    output logic [NAME_BITS-1:0]  ws,
    output logic [CTRL_BITS-1:0]  op,
    output logic                  imm_e,
    output logic [DATA_WIDTH-1:0] imm_d,
    output logic                  legal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] alu;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        rs1   = NAME_BITS'(instr[19:15]);
        ws    = NAME_BITS'(instr[11:7]);
        rs2   = '0;
        imm_e = 1'b0;
        legal = 1'b0;
        alu   = ALU_AND;
        imm_d = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
        case (opcode)
            OPC_R: begin
                rs2 = NAME_BITS'(instr[24:20]);
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  begin legal = 1'b1; alu = ALU_ADD; end
                        F3_AND:  begin legal = 1'b1; alu = ALU_AND; end
                        F3_OR:   begin legal = 1'b1; alu = ALU_OR;  end
                        F3_SLT:  begin legal = 1'b1; alu = ALU_SLT; end
                        default: legal = 1'b0;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    legal = 1'b1;
                    alu   = ALU_SUB;
                end
            end
            OPC_I: begin
                imm_e = 1'b1;
                case (f3)
                    F3_ADD:  begin legal = 1'b1; alu = ALU_ADD; end
                    F3_AND:  begin legal = 1'b1; alu = ALU_AND; end
                    F3_OR:   begin legal = 1'b1; alu = ALU_OR;  end
                    F3_SLT:  begin legal = 1'b1; alu = ALU_SLT; end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        op = CTRL_BITS'(alu);
    end

endmodule

// File: rtl/rv_decode_issue.sv
// Decode/issue stage: accepts RV32I words, issues one ALU op per clock and
// inserts bubbles while a source register was written by a recent issue.
module rv_decode_issue
    import rv_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NAME_BITS  = 5,
    parameter int CTRL_BITS  = 4,
    parameter int HAZARD_GAP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic [NAME_BITS-1:0]  rs1,
    output logic [NAME_BITS-1:0]  rs2,
    output logic [NAME_BITS-1:0]  ws,
    output logic [CTRL_BITS-1:0]  op,
    output logic                  imm_e,
    output logic [DATA_WIDTH-1:0] imm_d,
    output logic                  out_valid,
    output logic                  illegal
);

    // Handshake: a word moves only on a cycle where in_valid && in_ready are both
    // high at posedge; in_ready depends on state and rst only, never on in_valid.
    issue_state_t          state_q, state_d;
    logic [31:0]           held_q;
    logic [NAME_BITS-1:0]  sb_q [HAZARD_GAP];

    logic [31:0]           dec_word;
    logic [NAME_BITS-1:0]  dec_rs1, dec_rs2, dec_ws;
    logic [CTRL_BITS-1:0]  dec_op;
    logic                  dec_imm_e, dec_legal;
    logic [DATA_WIDTH-1:0] dec_imm_d;

    logic transfer, hazard, take, stall_ld, reject;

    assign in_ready = !rst && (state_q != ST_STALL);
    assign transfer = in_valid && in_ready;
    // While stalled the held word is re-decoded so the hazard check sees it.
    assign dec_word = (state_q == ST_STALL) ? held_q : instr;

    rv_alu_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .NAME_BITS  (NAME_BITS),
        .CTRL_BITS  (CTRL_BITS)
    ) u_dec (
        .instr (dec_word),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .ws    (dec_ws),
        .op    (dec_op),
        .imm_e (dec_imm_e),
        .imm_d (dec_imm_d),
        .legal (dec_legal)
    );

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZARD_GAP; i++) begin
            if (sb_q[i] != '0 &&
                (sb_q[i] == dec_rs1 || (!dec_imm_e && sb_q[i] == dec_rs2)))
                hazard = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        stall_ld = 1'b0;
        reject   = 1'b0;
        case (state_q)
            ST_STALL: begin
                if (!hazard) begin
                    take    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                if (!transfer) begin
                    state_d = ST_IDLE;
                end else if (!dec_legal) begin
                    reject  = 1'b1;
                    state_d = ST_IDLE;
                end else if (hazard) begin
                    stall_ld = 1'b1;
                    state_d  = ST_STALL;
                end else begin
                    take    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            held_q    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            ws        <= '0;
            op        <= '0;
            imm_e     <= 1'b0;
            imm_d     <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < HAZARD_GAP; i++) sb_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            if (stall_ld) held_q <= instr;
            rs1       <= take ? dec_rs1   : '0;
            rs2       <= take ? dec_rs2   : '0;
            ws        <= take ? dec_ws    : '0;
            op        <= take ? dec_op    : '0;
            imm_e     <= take ? dec_imm_e : 1'b0;
            imm_d     <= take ? dec_imm_d : '0;
            out_valid <= take;
            illegal   <= reject;
            // Bubbles and rejected words shift in 0 so they never act as producers.
            sb_q[0]   <= take ? dec_ws : '0;
            for (int i = 1; i < HAZARD_GAP; i++) sb_q[i] <= sb_q[i-1];
        end
    end

endmodule

// File: tb/tb_rv_decode_issue.sv
// Bench for rv_decode_issue: two instances (hazard gap 1 and 3) fed the same program,
// each checked every cycle against a slot-timing reference model.
module tb_rv_decode_issue;

    localparam int NB   = 5;
    localparam int DW   = 32;
    localparam int CB   = 4;
    localparam int GAP0 = 1;
    localparam int GAP1 = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld    [2];
    logic [31:0]   ins    [2];
    logic          rdy    [2];
    logic [NB-1:0] o_rs1  [2];
    logic [NB-1:0] o_rs2  [2];
    logic [NB-1:0] o_ws   [2];
    logic [CB-1:0] o_op   [2];
    logic          o_imme [2];
    logic [DW-1:0] o_immd [2];
    logic          o_ov   [2];
    logic          o_ill  [2];

    always #5 clk = ~clk;

    rv_decode_issue #(.DATA_WIDTH(DW), .NAME_BITS(NB), .CTRL_BITS(CB), .HAZARD_GAP(GAP0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .instr(ins[0]),
        .rs1(o_rs1[0]), .rs2(o_rs2[0]), .ws(o_ws[0]), .op(o_op[0]), .imm_e(o_imme[0]),
        .imm_d(o_immd[0]), .out_valid(o_ov[0]), .illegal(o_ill[0])
    );

    rv_decode_issue #(.DATA_WIDTH(DW), .NAME_BITS(NB), .CTRL_BITS(CB), .HAZARD_GAP(GAP1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .instr(ins[1]),
        .rs1(o_rs1[1]), .rs2(o_rs2[1]), .ws(o_ws[1]), .op(o_op[1]), .imm_e(o_imme[1]),
        .imm_d(o_immd[1]), .out_valid(o_ov[1]), .illegal(o_ill[1])
    );

    typedef struct {
        logic        legal;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  ws;
        logic [3:0]  op;
        logic        imm_e;
        logic [31:0] imm_d;
    } dec_t;

    int errors = 0;
    int checks = 0;

    int          gap_of  [2];
    logic [31:0] prog    [$];
    int          ptr     [2];
    bit          pres    [2];
    bit          gappy;
    int          slot;
    bit          m_pend  [2];
    logic [31:0] m_word  [2];
    int          last_wr [2][32];
    bit          measure;
    int          p1_slot [2];
    int          gap_obs [2];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] b,
                                          input logic [4:0] a, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, b, a, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] a,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, a, f3, rd, 7'b0010011};
    endfunction

    // Reference decode straight from the instruction-set table.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t r;
        r.legal = 1'b0;
        r.rs1   = w[19:15];
        r.ws    = w[11:7];
        r.rs2   = 5'd0;
        r.op    = 4'b0000;
        r.imm_e = 1'b0;
        r.imm_d = 32'($signed(w[31:20]));
        if (w[6:0] == 7'b0110011) begin
            r.rs2 = w[24:20];
            case ({w[31:25], w[14:12]})
                10'b0000000_000: begin r.legal = 1'b1; r.op = 4'b0010; end
                10'b0100000_000: begin r.legal = 1'b1; r.op = 4'b0110; end
                10'b0000000_111: begin r.legal = 1'b1; r.op = 4'b0000; end
                10'b0000000_110: begin r.legal = 1'b1; r.op = 4'b0001; end
                10'b0000000_010: begin r.legal = 1'b1; r.op = 4'b0111; end
                default:         r.legal = 1'b0;
            endcase
        end else if (w[6:0] == 7'b0010011) begin
            r.imm_e = 1'b1;
            case (w[14:12])
                3'b000:  begin r.legal = 1'b1; r.op = 4'b0010; end
                3'b111:  begin r.legal = 1'b1; r.op = 4'b0000; end
                3'b110:  begin r.legal = 1'b1; r.op = 4'b0001; end
                3'b010:  begin r.legal = 1'b1; r.op = 4'b0111; end
                default: r.legal = 1'b0;
            endcase
        end
        return r;
    endfunction

    // A register is busy if it was written within the last gap issue slots.
    function automatic bit busy(input int d, input logic [4:0] r);
        return (r != 5'd0) && (slot - last_wr[d][r] <= gap_of[d]);
    endfunction

    function automatic logic [31:0] rand_word();
        int          k;
        logic [4:0]  a, b, rd;
        logic [11:0] imm;
        k   = $urandom_range(0, 9);
        a   = 5'($urandom_range(0, 3));
        b   = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        imm = 12'($urandom());
        if (k < 4) begin
            case ($urandom_range(0, 4))
                0:       return enc_r(7'h00, b, a, 3'b000, rd);
                1:       return enc_r(7'h20, b, a, 3'b000, rd);
                2:       return enc_r(7'h00, b, a, 3'b111, rd);
                3:       return enc_r(7'h00, b, a, 3'b110, rd);
                default: return enc_r(7'h00, b, a, 3'b010, rd);
            endcase
        end else if (k < 8) begin
            case ($urandom_range(0, 3))
                0:       return enc_i(imm, a, 3'b000, rd);
                1:       return enc_i(imm, a, 3'b111, rd);
                2:       return enc_i(imm, a, 3'b110, rd);
                default: return enc_i(imm, a, 3'b010, rd);
            endcase
        end else if (k == 8) begin
            return enc_r(7'h01, b, a, 3'b000, rd);
        end
        return $urandom();
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic step();
        dec_t r;
        dec_t e      [2];
        bit   e_ov   [2];
        bit   e_ill  [2];
        bit   acc    [2];
        bit   was_rst;
        for (int d = 0; d < 2; d++) begin
            if (!pres[d] && ptr[d] < prog.size() && (!gappy || $urandom_range(0, 3) != 0))
                pres[d] = 1'b1;
            vld[d] = pres[d];
            ins[d] = pres[d] ? prog[ptr[d]] : $urandom();
        end
        #1;
        for (int d = 0; d < 2; d++)
            chk("in_ready", d, 32'(rdy[d]), 32'(!rst && !m_pend[d]));
        @(posedge clk);
        slot++;
        was_rst = rst;
        for (int d = 0; d < 2; d++) begin
            e[d]       = ref_decode(32'h0);
            e[d].rs1   = 5'd0;
            e[d].imm_d = 32'h0;
            e_ov[d]    = 1'b0;
            e_ill[d]   = 1'b0;
            acc[d]     = 1'b0;
            if (rst) begin
                m_pend[d] = 1'b0;
                for (int k = 0; k < 32; k++) last_wr[d][k] = -100;
            end else if (m_pend[d] || vld[d]) begin
                if (!m_pend[d]) begin
                    acc[d]    = 1'b1;
                    m_word[d] = ins[d];
                end
                r = ref_decode(m_word[d]);
                if (!r.legal) begin
                    e_ill[d]  = 1'b1;
                    m_pend[d] = 1'b0;
                end else if (busy(d, r.rs1) || (!r.imm_e && busy(d, r.rs2))) begin
                    m_pend[d] = 1'b1;
                end else begin
                    m_pend[d] = 1'b0;
                    e[d]      = r;
                    e_ov[d]   = 1'b1;
                    if (r.ws != 5'd0) last_wr[d][r.ws] = slot;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rs1",       d, 32'(o_rs1[d]),  32'(e[d].rs1));
            chk("rs2",       d, 32'(o_rs2[d]),  32'(e[d].rs2));
            chk("ws",        d, 32'(o_ws[d]),   32'(e[d].ws));
            chk("op",        d, 32'(o_op[d]),   32'(e[d].op));
            chk("imm_e",     d, 32'(o_imme[d]), 32'(e[d].imm_e));
            chk("out_valid", d, 32'(o_ov[d]),   32'(e_ov[d]));
            chk("illegal",   d, 32'(o_ill[d]),  32'(e_ill[d]));
            if (e_ov[d] || was_rst) chk("imm_d", d, o_immd[d], e[d].imm_d);
            if (acc[d]) begin
                ptr[d]++;
                pres[d] = 1'b0;
            end
            if (measure && o_ov[d] && o_ws[d] == 5'd1) p1_slot[d] = slot;
            if (measure && o_ov[d] && o_ws[d] == 5'd2) gap_obs[d] = slot - p1_slot[d] - 1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((ptr[0] < prog.size() || ptr[1] < prog.size() || m_pend[0] || m_pend[1])
               && budget < 100) begin
            step();
            budget++;
        end
        checks++;
        if (budget >= 100) begin
            errors++;
            $display("FAIL drain_timeout observed=%0d cycles required=<100", budget);
        end
        for (int k = 0; k < 5; k++) step();
    endtask

    initial begin
        gap_of[0] = GAP0;
        gap_of[1] = GAP1;
        gappy     = 1'b0;
        measure   = 1'b0;
        slot      = 0;
        for (int d = 0; d < 2; d++) begin
            ptr[d]     = 0;
            pres[d]    = 1'b0;
            m_pend[d]  = 1'b0;
            m_word[d]  = 32'h0;
            vld[d]     = 1'b0;
            ins[d]     = 32'h0;
            p1_slot[d] = 0;
            gap_obs[d] = -1;
            for (int k = 0; k < 32; k++) last_wr[d][k] = -100;
        end

        // Reset held for three cycles while a word is offered; then ADDI x1,x0,5.
        rst = 1'b1;
        prog.push_back(32'h00500093);
        for (int k = 0; k < 3; k++) step();
        rst = 1'b0;
        drain();

        // Dependent pair: bubble count must equal each instance's gap.
        measure = 1'b1;
        prog.push_back(32'h00500093);
        prog.push_back(32'h00008133);
        drain();
        measure = 1'b0;
        for (int d = 0; d < 2; d++) chk("dep_bubbles", d, gap_obs[d], gap_of[d]);

        // Independent words, SUB, then a consumer of x4 and sign-extended immediates.
        prog.push_back(enc_i(12'd7, 5'd0, 3'b000, 5'd5));
        prog.push_back(enc_i(12'd1, 5'd0, 3'b110, 5'd6));
        prog.push_back(32'h40300233);
        prog.push_back(enc_r(7'h00, 5'd0, 5'd4, 3'b111, 5'd7));
        prog.push_back(enc_i(12'hfff, 5'd9, 3'b010, 5'd8));
        prog.push_back(enc_i(12'h800, 5'd0, 3'b111, 5'd10));
        prog.push_back(enc_r(7'h00, 5'd11, 5'd12, 3'b010, 5'd13));
        prog.push_back(enc_r(7'h00, 5'd13, 5'd0, 3'b110, 5'd14));
        drain();

        // Unsupported words: MUL and an unknown opcode, each followed by a real word.
        prog.push_back(32'h02208033);
        prog.push_back(enc_i(12'd3, 5'd0, 3'b000, 5'd15));
        prog.push_back(32'h0000006f);
        prog.push_back(enc_r(7'h00, 5'd15, 5'd15, 3'b000, 5'd16));
        drain();

        // Reset while the dependent word is stalled; next word must issue cleanly.
        prog.push_back(32'h00500093);
        prog.push_back(32'h00008133);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        prog.push_back(enc_i(12'd9, 5'd0, 3'b000, 5'd3));
        drain();

        // Random traffic with idle gaps and occasional reset pulses.
        gappy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (prog.size() - ptr[0] < 4 && prog.size() - ptr[1] < 4)
                prog.push_back(rand_word());
            rst = ($urandom_range(0, 80) == 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
